// File: rtl/spi_sd_master.sv
// SPI mode-0 master byte engine for the SD-card interface: serial (lane 0) or
// octal byte exchange with a valid/ready push side and a one-cycle rx pulse.
module spi_sd_master #(
    parameter int unsigned DIV_W   = 8,
    parameter logic [7:0]  IDLE_TX = 8'hFF
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             octal,
    input  logic             cs_wr,
    input  logic             cs_val,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             busy,
    output logic             sck,
    output logic [7:0]       mosi,
    input  logic [7:0]       miso,
    output logic             ss
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             oct_q, oct_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [2:0]       bit_q, bit_d;
    logic             ss_q, ss_d;
    logic             cs_pend_q, cs_pend_d;
    logic             cs_pend_val_q, cs_pend_val_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            div_q         <= '0;
            oct_q         <= 1'b0;
            tx_q          <= '0;
            rx_q          <= '0;
            rx_data_q     <= '0;
            bit_q         <= '0;
            ss_q          <= 1'b1;
            cs_pend_q     <= 1'b0;
            cs_pend_val_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            oct_q         <= oct_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            rx_data_q     <= rx_data_d;
            bit_q         <= bit_d;
            ss_q          <= ss_d;
            cs_pend_q     <= cs_pend_d;
            cs_pend_val_q <= cs_pend_val_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        oct_d         = oct_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        rx_data_d     = rx_data_q;
        bit_d         = bit_q;
        ss_d          = ss_q;
        cs_pend_d     = cs_pend_q;
        cs_pend_val_d = cs_pend_val_q;

        unique case (state_q)
            IDLE: begin
                // chip-select update and a transfer accept may share a cycle
                if (cs_wr) ss_d = cs_val;
                if (tx_valid) begin
                    state_d = LOW;
                    div_d   = div;
                    oct_d   = octal;
                    tx_d    = tx_data;
                    cnt_d   = div;
                    bit_d   = '0;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = div_q;
                    rx_d    = oct_q ? miso : {rx_q[6:0], miso[0]};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    bit_d = bit_q + 3'd1;
                    if (oct_q || bit_q == 3'd7) begin
                        state_d   = DONE;
                        rx_data_d = rx_q;
                    end else begin
                        state_d = LOW;
                        tx_d    = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                cs_pend_d = 1'b0;
                if (cs_wr)          ss_d = cs_val;
                else if (cs_pend_q) ss_d = cs_pend_val_q;
            end
            default: state_d = IDLE;
        endcase

        if (cs_wr && (state_q == LOW || state_q == HIGH)) begin
            cs_pend_d     = 1'b1;
            cs_pend_val_d = cs_val;
        end
    end

    // sck/mosi decode straight from reset flops so an abort idles the lines at once
    always_comb begin
        mosi = IDLE_TX;
        if (state_q == LOW || state_q == HIGH)
            mosi = oct_q ? tx_q : {7'h7F, tx_q[7]};
    end

    assign sck      = (state_q == HIGH);
    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign rx_valid = (state_q == DONE);
    assign rx_data  = rx_data_q;
    assign ss       = ss_q;

endmodule

// File: tb/tb_spi_sd_master.sv
// Randomized scoreboard bench for spi_sd_master: a slave-side model answers on
// miso and captures mosi; every accepted byte queues its expected exchange.
module tb_spi_sd_master;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [7:0] div;
    logic       octal, cs_wr, cs_val, tx_valid, tx_ready;
    logic [7:0] tx_data, rx_data, mosi, miso;
    logic       rx_valid, busy, sck, ss;

    always #5 clk_sys = ~clk_sys;

    spi_sd_master #(.DIV_W(8), .IDLE_TX(8'hFF)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .div     (div),
        .octal   (octal),
        .cs_wr   (cs_wr),
        .cs_val  (cs_val),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .busy    (busy),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso),
        .ss      (ss)
    );

    typedef struct {
        logic [7:0]  tx;
        logic [7:0]  resp;
        logic        oct;
        logic [7:0]  dv;
        int unsigned t0;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // slave model: serves resp MSB-first on lane 0 (or whole byte in octal)
    // and captures mosi on each sck rising edge
    logic [2:0] idx;
    logic       sck_prev;
    logic [7:0] cap;
    int         pulses, hi_len;
    logic       line_ok;
    logic [6:0] miso_hi;
    exp_t       e, e0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            exp_q.delete();
            idx = '0; cap = '0; pulses = 0; hi_len = 0; line_ok = 1'b1; sck_prev = 1'b0;
        end else begin
            if (sck && !sck_prev) begin
                idx++;
                pulses++;
                if (exp_q.size() > 0 && exp_q[0].oct) cap = mosi;
                else begin
                    cap = {cap[6:0], mosi[0]};
                    if (mosi[7:1] !== 7'h7F) line_ok = 1'b0;
                end
            end
            if (sck) hi_len++;
            else if (sck_prev) begin
                if (exp_q.size() == 0 || hi_len != int'(exp_q[0].dv) + 1) line_ok = 1'b0;
                hi_len = 0;
            end
            if ((!busy || rx_valid) && (sck || mosi !== 8'hFF)) line_ok = 1'b0;
            if (rx_valid) begin
                if (exp_q.size() == 0) chk("unexpected_rx", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("rx_data", rx_data, e.resp);
                    chk("latency", cyc - e.t0,
                        e.oct ? 2 * (32'(e.dv) + 1) + 1 : 16 * (32'(e.dv) + 1) + 1);
                    chk("mosi_byte", cap, e.tx);
                    chk("sck_pulses", pulses, e.oct ? 1 : 8);
                    chk("line_shape", line_ok, 1);
                end
                idx = '0; cap = '0; pulses = 0; line_ok = 1'b1;
                miso_hi = 7'($urandom);
            end
            sck_prev = sck;
        end
        if (exp_q.size() > 0) begin
            e0 = exp_q[0];
            miso = e0.oct ? e0.resp : {miso_hi, e0.resp[3'd7 - idx]};
        end else begin
            miso = {miso_hi, 1'b1};
        end
    end

    task automatic xfer(input logic [7:0] tx, input logic [7:0] resp, input logic oct,
                        input logic [7:0] dv, input logic do_cs, input logic csv,
                        output int unsigned t0);
        int   n = 0;
        exp_t x;
        tx_valid = 1'b1; tx_data = tx; octal = oct; div = dv; cs_wr = do_cs; cs_val = csv;
        while (!tx_ready && n < 2000) begin @(negedge clk_sys); n++; end
        t0 = cyc;
        if (!tx_ready) begin
            chk("accept_timeout", n, 0);
            tx_valid = 1'b0; cs_wr = 1'b0;
            return;
        end
        x.tx = tx; x.resp = resp; x.oct = oct; x.dv = dv; x.t0 = cyc;
        exp_q.push_back(x);
        @(negedge clk_sys);
        // latched settings must not follow these mid-transfer changes
        tx_valid = 1'b0; cs_wr = 1'b0;
        div = 8'($urandom); octal = 1'($urandom); tx_data = 8'($urandom);
    endtask

    task automatic wait_idle(output int unsigned t);
        int n = 0;
        while (!tx_ready && n < 2000) begin @(negedge clk_sys); n++; end
        if (!tx_ready) chk("idle_timeout", n, 0);
        t = cyc;
    endtask

    task automatic wait_rx();
        int n = 0;
        while (!rx_valid && n < 2000) begin @(negedge clk_sys); n++; end
        if (!rx_valid) chk("rx_timeout", n, 0);
    endtask

    int unsigned t0, t1, t2;
    logic [7:0]  r;

    initial begin
        miso_hi = 7'h55;
        reset_n = 1'b0; tx_valid = 1'b0; cs_wr = 1'b0; cs_val = 1'b1;
        div = '0; octal = 1'b0; tx_data = '0;
        repeat (2) @(negedge clk_sys);
        chk("reset_state", {sck, ss, mosi, rx_valid, rx_data, tx_ready, busy},
            {1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0});
        reset_n = 1'b1;
        @(negedge clk_sys);

        // serial, div=0, select card first
        cs_wr = 1'b1; cs_val = 1'b0;
        @(negedge clk_sys);
        cs_wr = 1'b0;
        chk("ss_idle_write", ss, 0);
        xfer(8'hA5, 8'h3C, 1'b0, 8'd0, 1'b0, 1'b0, t0);
        wait_idle(t1);
        chk("ready_lat_div0", t1 - t0, 18);

        // serial, div=3
        xfer(8'h00, 8'($urandom), 1'b0, 8'd3, 1'b0, 1'b0, t0);
        wait_idle(t1);
        chk("ready_lat_div3", t1 - t0, 66);
        chk("idle_mosi", mosi, 8'hFF);

        // octal, div=1
        xfer(8'h5A, 8'hC3, 1'b1, 8'd1, 1'b0, 1'b0, t0);
        wait_idle(t1);
        chk("ready_lat_octal", t1 - t0, 6);

        // back-to-back with tx_valid held
        xfer(8'h01, 8'($urandom), 1'b0, 8'd0, 1'b0, 1'b0, t1);
        xfer(8'h02, 8'($urandom), 1'b0, 8'd0, 1'b0, 1'b0, t2);
        chk("b2b_accept_gap", t2 - t1, 18);
        wait_idle(t0);

        // deselect request during bit 3 is deferred to the first idle cycle
        xfer(8'($urandom), 8'($urandom), 1'b0, 8'd1, 1'b0, 1'b0, t0);
        repeat (12) @(negedge clk_sys);
        cs_wr = 1'b1; cs_val = 1'b1;
        @(negedge clk_sys);
        cs_wr = 1'b0;
        chk("ss_pending_busy", ss, 0);
        wait_rx();
        chk("ss_pending_done", ss, 0);
        @(negedge clk_sys);
        chk("ss_applied_idle", {tx_ready, ss}, 2'b11);

        // reset during bit 5, then recover with cs write coincident with accept
        r = 8'($urandom);
        xfer(8'($urandom), r, 1'b0, 8'd0, 1'b0, 1'b0, t0);
        repeat (10) @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", {sck, ss, mosi, busy, rx_valid, tx_ready},
               {1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1});
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        xfer(8'hE7, 8'h81, 1'b0, 8'd2, 1'b1, 1'b0, t0);
        chk("ss_with_accept", ss, 0);
        wait_idle(t1);
        chk("ready_lat_after_rst", t1 - t0, 50);

        // randomized traffic, mixing back-to-back and idle gaps
        for (int i = 0; i < 30; i++) begin
            xfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 3)), 1'b0, 1'b0, t0);
            if ($urandom_range(0, 1) == 1) begin
                wait_idle(t1);
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            end
        end
        wait_idle(t1);
        @(negedge clk_sys);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
